// File: rtl/lutram_fifo16.sv
// lutram_fifo16 - 16-entry synchronous show-ahead FIFO on distributed RAM.
//
// Storage is a 16 x WIDTH array written synchronously and read
// asynchronously at rd_ptr, so the head word is visible on dout with no
// read latency. Occupancy is tracked in a 5-bit counter; empty/full/afull
// are decoded from that counter, never from a pointer compare.
//
// Ports:
//   clk      in   system clock, all state changes on the rising edge
//   rst      in   synchronous active-high reset (pointers, count, errors)
//   wr       in   push request, din written when accepted
//   din      in   write data [WIDTH-1:0]
//   rd       in   pop request, advances the head when accepted
//   dout     out  head-of-queue data, undefined while empty
//   empty    out  count == 0
//   full     out  count == 16
//   afull    out  count >= AFULL
//   count    out  occupancy 0..16
//   ovf      out  sticky: a push was rejected
//   udf      out  sticky: a pop was rejected
//   clr_err  in   clears ovf/udf (a new error in the same cycle wins)

module lutram_fifo16 #(
   parameter int WIDTH = 8,
   parameter int AFULL = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             rd,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic             afull,
   output logic [4:0]       count,
   output logic             ovf,
   output logic             udf,
   input  logic             clr_err
);

   logic [WIDTH-1:0] mem [16];
   logic [3:0]       wr_ptr;
   logic [3:0]       rd_ptr;
   logic             acc_w;
   logic             acc_r;
   logic             rej_w;
   logic             rej_r;

   // Flags decode the registered count, so they all move on the same edge.
   assign empty = (count == 5'd0);
   assign full  = (count == 5'd16);
   assign afull = (count >= 5'(AFULL));

   // A pop on a full FIFO frees the head slot before the edge, letting a
   // simultaneous push land in it.
   assign acc_r = rd & ~empty;
   assign acc_w = wr & (~full | acc_r);
   assign rej_w = wr & ~acc_w;
   assign rej_r = rd & empty;

   assign dout = mem[rd_ptr];

   // RAM has no reset: contents survive rst, only the pointers move.
   always_ff @(posedge clk) begin
      if (acc_w && !rst)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (acc_w)
            wr_ptr <= wr_ptr + 4'd1;
         if (acc_r)
            rd_ptr <= rd_ptr + 4'd1;
         if (acc_w && !acc_r)
            count <= count + 5'd1;
         else if (acc_r && !acc_w)
            count <= count - 5'd1;

         if (rej_w)
            ovf <= 1'b1;
         else if (clr_err)
            ovf <= 1'b0;

         if (rej_r)
            udf <= 1'b1;
         else if (clr_err)
            udf <= 1'b0;
      end
   end

endmodule
